instr_seq_feeder: RTL and testbench
===================================

INSTR_SEQ_FEEDER -- requirements
Module: instr_seq_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16: number of program-table entries (power of two, >=2).
REQ-002 The block SHALL have parameter XLEN, default 32: instruction word width.
REQ-003 The block SHALL have parameter CNT_W, default 8: width of the repeat and gap counters.
REQ-004 The block SHALL have port cpu_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port cpu_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port cfg_we, input, 1 bit: table write strobe.
REQ-007 The block SHALL have port cfg_addr, input, clog2(DEPTH) bits: table write index.
REQ-008 The block SHALL have port cfg_instr, input, XLEN bits: instruction word to store.
REQ-009 The block SHALL have port cfg_rep, input, CNT_W bits: issue count for the entry (0 means 1).
REQ-010 The block SHALL have port cfg_gap, input, CNT_W bits: idle cycles after the entry.
REQ-011 The block SHALL have port num_entries, input, clog2(DEPTH)+1 bits: program length, sampled at start.
REQ-012 The block SHALL have port loop_en, input, 1 bit: restart from entry 0 after the last entry, sampled at start.
REQ-013 The block SHALL have port start, input, 1 bit: run request.
REQ-014 The block SHALL have port abort, input, 1 bit: stop request.
REQ-015 The block SHALL have port stall, input, 1 bit: consumer not accepting the current issue.
REQ-016 The block SHALL have port cpu_instruction, output, XLEN bits: instruction presented to the CPU.
REQ-017 The block SHALL have port cpu_instruction_RDY_BSY, output, 1 bit: cpu_instruction valid.
REQ-018 The block SHALL have port busy, output, 1 bit: high in any state except IDLE.
REQ-019 The block SHALL have port done, output, 1 bit: one-cycle end-of-program pulse.
REQ-020 The block SHALL have port err, output, 1 bit: sticky flag for an illegal start.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, ISSUE, GAP and DONE.
REQ-022 The block SHALL write the table entry (instr, rep, gap) at cfg_addr only when cfg_we=1 in IDLE, and SHALL ignore cfg_we in every other state.
REQ-023 On start=1 in IDLE with 1<=num_entries<=DEPTH, the block SHALL latch num_entries and loop_en, set ptr=0, load rep_cnt from entry 0, and enter ISSUE on the next edge.
REQ-024 On start=1 in IDLE with num_entries=0 or num_entries>DEPTH, the block SHALL set err=1, remain in IDLE, and hold err until the next legal start or reset.
REQ-025 When cfg_we=1 and start=1 in the same IDLE cycle, the write SHALL complete first, and the run SHALL use the updated table.
REQ-026 The block SHALL ignore start outside IDLE.
REQ-027 Latency: if start is sampled at edge t, cpu_instruction_RDY_BSY SHALL be 1 with entry 0 from the cycle after edge t.
REQ-028 In ISSUE, the block SHALL drive cpu_instruction=table[ptr] and cpu_instruction_RDY_BSY=1.
REQ-029 In ISSUE, an issue SHALL be consumed only on a cycle with stall=0, and rep_cnt SHALL decrement by one per consumed issue.
REQ-030 With stall=1, all state, ptr, rep_cnt and outputs SHALL hold.
REQ-031 After the last repeat of an entry is consumed: if gap>0, the block SHALL enter GAP with gap_cnt=gap; otherwise it SHALL advance immediately.
REQ-032 In GAP, the block SHALL drive cpu_instruction=0 and RDY_BSY=0, decrement gap_cnt every cycle regardless of stall, and advance when gap_cnt reaches 1.
REQ-033 On advance from ptr<num-1, the block SHALL set ptr+1, reload rep_cnt, and enter ISSUE.
REQ-034 On advance from ptr=num-1, the block SHALL wrap to ptr=0 in ISSUE if loop_en was latched, and SHALL otherwise enter DONE.
REQ-035 In DONE, the block SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-036 abort=1 in any non-IDLE state SHALL return the block to IDLE on the next edge with RDY_BSY=0 and no done pulse.
REQ-037 abort SHALL take priority over stall and over advance.
REQ-038 Outside ISSUE, the block SHALL hold cpu_instruction=0 and RDY_BSY=0.
REQ-039 All counters SHALL be unsigned CNT_W bits, and no counter SHALL wrap below zero.
REQ-040 All outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-041 When cpu_rst=1 at a clock edge, the block SHALL enter IDLE with ptr=0 and rep_cnt=gap_cnt=0.
REQ-042 Reset SHALL leave every output at 0: cpu_instruction, cpu_instruction_RDY_BSY, busy, done and err.
REQ-043 Table contents SHALL not be reset; reset mid-run SHALL override abort and start.

Structure
REQ-044 Package instr_feeder_pkg SHALL hold the FSM state enum, the I_TYPE_OP (0010011) and R_TYPE_OP (0110011) opcode constants, and a zero/NOP word constant.
REQ-045 The table SHALL be a sub-module feeder_table: DEPTH-entry register array with one write port and one combinational read port.

Verification
REQ-046 Load entry0={0x00500093, rep=3, gap=0}, num=1, loop=0, start -> 0x00500093 with RDY_BSY=1 for exactly 3 cycles, then done pulse, then busy=0.
REQ-047 Load entries {0x00500093 rep1 gap2}, {0x00508113 rep1 gap0}, {0x002001B3 rep2 gap0}, num=3 -> issue sequence 0x00500093, 0,0, 0x00508113, 0x002001B3, 0x002001B3, then done.
REQ-048 Stall held 4 cycles in the middle of the rep=3 run -> instruction held stable, total RDY_BSY cycles = 7, exactly 3 consumed.
REQ-049 loop_en=1, num=2, then abort after 10 cycles -> the sequence wraps to entry 0, RDY_BSY=0 the next cycle, done never asserted.
REQ-050 start with num=0, then with num=DEPTH+1 -> err=1, busy=0; a following legal start clears err.
REQ-051 cpu_rst asserted during GAP -> all outputs 0 next cycle; a restart without rewriting the table replays the original program.

Source files
------------

// File: rtl/instr_feeder_pkg.sv
// Shared types and constants for the instruction sequence feeder.
// Holds the FSM state encoding, RISC-V opcode constants and the idle bus word.
package instr_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

  localparam logic [6:0]  I_TYPE_OP = 7'b0010011;
  localparam logic [6:0]  R_TYPE_OP = 7'b0110011;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Opcode field of a 32-bit RISC-V instruction word.
  function automatic logic [6:0] opcode_of(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/feeder_table.sv
// Program table: DEPTH entries of {instruction, repeat, gap}.
// One synchronous write port and one combinational read port; contents are never reset.
module feeder_table
  import instr_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [XLEN-1:0]          winstr_i,
  input  logic [CNT_W-1:0]         wrep_i,
  input  logic [CNT_W-1:0]         wgap_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [XLEN-1:0]          rinstr_o,
  output logic [CNT_W-1:0]         rrep_o,
  output logic [CNT_W-1:0]         rgap_o
);

  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [CNT_W-1:0] rep_mem   [DEPTH];
  logic [CNT_W-1:0] gap_mem   [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      instr_mem[waddr_i] <= winstr_i;
      rep_mem[waddr_i]   <= wrep_i;
      gap_mem[waddr_i]   <= wgap_i;
    end
  end

  assign rinstr_o = instr_mem[raddr_i];
  assign rrep_o   = rep_mem[raddr_i];
  assign rgap_o   = gap_mem[raddr_i];

endmodule

// File: rtl/instr_seq_feeder.sv
// Replays a small programmed instruction table to a CPU: each entry is issued
// rep times (consumed only when not stalled), followed by gap idle cycles.
module instr_seq_feeder
  import instr_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [XLEN-1:0]          cfg_instr,
  input  logic [CNT_W-1:0]         cfg_rep,
  input  logic [CNT_W-1:0]         cfg_gap,
  input  logic [$clog2(DEPTH):0]   num_entries,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     stall,
  output logic [XLEN-1:0]          cpu_instruction,
  output logic                     cpu_instruction_RDY_BSY,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;

  feeder_state_e    state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d, rd_addr;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] cur_gap_q, cur_gap_d;
  logic [XLEN-1:0]  cur_instr_q, cur_instr_d;
  logic [NW-1:0]    num_q, num_d;
  logic             loop_q, loop_d;
  logic             err_q, err_d;
  logic [XLEN-1:0]  instr_out_q, instr_out_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tbl_we;
  logic [XLEN-1:0]  tbl_instr, ent_instr;
  logic [CNT_W-1:0] tbl_rep, tbl_gap, ent_rep, ent_gap, rep_load;
  logic             last_entry, num_ok, advance;

  assign tbl_we = cfg_we && (state_q == IDLE);

  feeder_table #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_table (
    .clk_i    (cpu_clk),
    .we_i     (tbl_we),
    .waddr_i  (cfg_addr),
    .winstr_i (cfg_instr),
    .wrep_i   (cfg_rep),
    .wgap_i   (cfg_gap),
    .raddr_i  (rd_addr),
    .rinstr_o (tbl_instr),
    .rrep_o   (tbl_rep),
    .rgap_o   (tbl_gap)
  );

  assign last_entry = (ptr_q == AW'(num_q - NW'(1)));
  assign num_ok     = (num_entries != '0) && (num_entries <= NW'(DEPTH));

  // The read port always looks at the entry to be loaded next: entry 0 from IDLE, else ptr+1 with wrap.
  always_comb begin
    rd_addr = ptr_q + AW'(1);
    if (state_q == IDLE || last_entry) rd_addr = '0;
  end

  // A write in the start cycle is forwarded so the run sees the updated entry.
  always_comb begin
    ent_instr = tbl_instr;
    ent_rep   = tbl_rep;
    ent_gap   = tbl_gap;
    if (tbl_we && (cfg_addr == rd_addr)) begin
      ent_instr = cfg_instr;
      ent_rep   = cfg_rep;
      ent_gap   = cfg_gap;
    end
  end

  assign rep_load = (ent_rep == '0) ? CNT_W'(1) : ent_rep;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rep_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      cur_gap_q   <= '0;
      cur_instr_q <= '0;
      num_q       <= '0;
      loop_q      <= 1'b0;
      err_q       <= 1'b0;
      instr_out_q <= '0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rep_cnt_q   <= rep_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      cur_gap_q   <= cur_gap_d;
      cur_instr_q <= cur_instr_d;
      num_q       <= num_d;
      loop_q      <= loop_d;
      err_q       <= err_d;
      instr_out_q <= instr_out_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and counter update; abort wins over stall and advance.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rep_cnt_d   = rep_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    cur_gap_d   = cur_gap_q;
    cur_instr_d = cur_instr_q;
    num_d       = num_q;
    loop_d      = loop_q;
    err_d       = err_q;
    advance     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_ok) begin
            num_d       = num_entries;
            loop_d      = loop_en;
            err_d       = 1'b0;
            ptr_d       = '0;
            rep_cnt_d   = rep_load;
            cur_gap_d   = ent_gap;
            cur_instr_d = ent_instr;
            state_d     = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!stall) begin
          if (rep_cnt_q > CNT_W'(1)) begin
            rep_cnt_d = rep_cnt_q - CNT_W'(1);
          end else begin
            rep_cnt_d = '0;
            if (cur_gap_q != '0) begin
              gap_cnt_d = cur_gap_q;
              state_d   = GAP;
            end else begin
              advance = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - CNT_W'(1);
          if (gap_cnt_q <= CNT_W'(1)) advance = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (last_entry && !loop_q) begin
        state_d = DONE;
      end else begin
        ptr_d       = rd_addr;
        rep_cnt_d   = rep_load;
        cur_gap_d   = ent_gap;
        cur_instr_d = ent_instr;
        state_d     = ISSUE;
      end
    end
  end

  // Output decode of the next state, captured in registers.
  always_comb begin
    rdy_d       = (state_d == ISSUE);
    instr_out_d = rdy_d ? cur_instr_d : XLEN'(ZERO_WORD);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  assign cpu_instruction         = instr_out_q;
  assign cpu_instruction_RDY_BSY = rdy_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign err                     = err_q;

endmodule

// File: tb/tb_instr_seq_feeder.sv
// Directed self-checking bench for instr_seq_feeder.
module tb_instr_seq_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [31:0] I0 = 32'h0050_0093;
  localparam logic [31:0] I1 = 32'h0050_8113;
  localparam logic [31:0] I2 = 32'h0020_01B3;
  localparam logic [31:0] I7 = 32'h00A0_0093;

  logic             cpu_clk = 1'b0;
  logic             cpu_rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [3:0]       cfg_addr = '0;
  logic [XLEN-1:0]  cfg_instr = '0;
  logic [CNT_W-1:0] cfg_rep = '0;
  logic [CNT_W-1:0] cfg_gap = '0;
  logic [4:0]       num_entries = '0;
  logic             loop_en = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             stall = 1'b0;
  logic [XLEN-1:0]  cpu_instruction;
  logic             cpu_instruction_RDY_BSY;
  logic             busy;
  logic             done;
  logic             err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp3_instr [6] = '{I0, 32'h0, 32'h0, I1, I2, I2};
  logic        exp3_rdy   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  instr_seq_feeder #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .cpu_clk                 (cpu_clk),
    .cpu_rst                 (cpu_rst),
    .cfg_we                  (cfg_we),
    .cfg_addr                (cfg_addr),
    .cfg_instr               (cfg_instr),
    .cfg_rep                 (cfg_rep),
    .cfg_gap                 (cfg_gap),
    .num_entries             (num_entries),
    .loop_en                 (loop_en),
    .start                   (start),
    .abort                   (abort),
    .stall                   (stall),
    .cpu_instruction         (cpu_instruction),
    .cpu_instruction_RDY_BSY (cpu_instruction_RDY_BSY),
    .busy                    (busy),
    .done                    (done),
    .err                     (err)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [31:0] ins,
                             input logic [7:0] r, input logic [7:0] g);
    cfg_we = 1'b1; cfg_addr = a; cfg_instr = ins; cfg_rep = r; cfg_gap = g;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input logic [4:0] n, input logic lp);
    num_entries = n; loop_en = lp; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_instr"}, cpu_instruction, 32'h0);
    chk({tag, "_rdy"}, 32'(cpu_instruction_RDY_BSY), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  task automatic run_seq3(input string tag);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s_instr%0d", tag, i), cpu_instruction, exp3_instr[i]);
      chk($sformatf("%s_rdy%0d", tag, i), 32'(cpu_instruction_RDY_BSY), 32'(exp3_rdy[i]));
      cycle();
    end
    chk({tag, "_done"}, 32'(done), 32'h1);
    cycle();
    chk({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int rdy_cnt;
    int cons_cnt;
    int done_cnt;
    logic [31:0] held;

    // Reset state
    cycle();
    cycle();
    chk_all_zero("reset");
    cpu_rst = 1'b0;

    // Single entry issued three times
    write_entry(4'd0, I0, 8'd3, 8'd0);
    start_run(5'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rep3_instr%0d", i), cpu_instruction, I0);
      chk($sformatf("rep3_rdy%0d", i), 32'(cpu_instruction_RDY_BSY), 32'h1);
      cycle();
    end
    chk("rep3_done", 32'(done), 32'h1);
    chk("rep3_done_rdy", 32'(cpu_instruction_RDY_BSY), 32'h0);
    chk("rep3_done_busy", 32'(busy), 32'h1);
    cycle();
    chk("rep3_done_drop", 32'(done), 32'h0);
    chk("rep3_busy_drop", 32'(busy), 32'h0);

    // Stall for four cycles in the middle of the rep=3 run
    start_run(5'd1, 1'b0);
    rdy_cnt = 0; cons_cnt = 0; done_cnt = 0;
    held = cpu_instruction;
    for (int n = 0; n < 20; n++) begin
      stall = (n >= 1 && n <= 4);
      if (stall) chk($sformatf("stall_hold%0d", n), cpu_instruction, held);
      if (cpu_instruction_RDY_BSY) begin
        rdy_cnt++;
        if (!stall) cons_cnt++;
      end
      if (done) done_cnt++;
      if (!busy) break;
      cycle();
    end
    stall = 1'b0;
    chk("stall_rdy_cycles", 32'(rdy_cnt), 32'd7);
    chk("stall_consumed", 32'(cons_cnt), 32'd3);
    chk("stall_done_pulses", 32'(done_cnt), 32'd1);
    chk("stall_ended", 32'(busy), 32'h0);

    // Three-entry program with a gap after entry 0
    write_entry(4'd0, I0, 8'd1, 8'd2);
    write_entry(4'd1, I1, 8'd1, 8'd0);
    write_entry(4'd2, I2, 8'd2, 8'd0);
    start_run(5'd3, 1'b0);
    run_seq3("seq3");

    // Looping two-entry program, aborted while issuing the last entry
    start_run(5'd2, 1'b1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("loop_instr%0d", i), cpu_instruction,
          (i % 4 == 0) ? I0 : ((i % 4 == 3) ? I1 : 32'h0));
      chk($sformatf("loop_done%0d", i), 32'(done), 32'h0);
      if (i == 11) abort = 1'b1;
      cycle();
    end
    abort = 1'b0;
    chk("abort_rdy", 32'(cpu_instruction_RDY_BSY), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_instr", cpu_instruction, 32'h0);
    cycle();
    chk("abort_done_after", 32'(done), 32'h0);

    // Illegal program lengths set a sticky error; a legal start clears it
    start_run(5'd0, 1'b0);
    chk("err_num0", 32'(err), 32'h1);
    chk("err_num0_busy", 32'(busy), 32'h0);
    cycle();
    chk("err_sticky", 32'(err), 32'h1);
    start_run(5'(DEPTH + 1), 1'b0);
    chk("err_numbig", 32'(err), 32'h1);
    chk("err_numbig_busy", 32'(busy), 32'h0);
    start_run(5'd1, 1'b0);
    chk("err_cleared", 32'(err), 32'h0);
    chk("err_legal_busy", 32'(busy), 32'h1);
    chk("err_legal_instr", cpu_instruction, I0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("err_abort_idle", 32'(busy), 32'h0);

    // Table write during a run is ignored; reset in GAP; replay the original program
    start_run(5'd3, 1'b0);
    chk("rst_first_instr", cpu_instruction, I0);
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_instr = 32'hDEAD_BEEF; cfg_rep = 8'd5; cfg_gap = 8'd0;
    cycle();
    cfg_we = 1'b0;
    chk("rst_in_gap_rdy", 32'(cpu_instruction_RDY_BSY), 32'h0);
    chk("rst_in_gap_busy", 32'(busy), 32'h1);
    cpu_rst = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    cycle();
    cpu_rst = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    chk_all_zero("midrst");
    start_run(5'd3, 1'b0);
    run_seq3("replay");

    // Write and start in the same cycle: the run uses the new entry 0
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_instr = I7; cfg_rep = 8'd2; cfg_gap = 8'd0;
    num_entries = 5'd1; loop_en = 1'b0; start = 1'b1;
    cycle();
    cfg_we = 1'b0; start = 1'b0;
    chk("wstart_instr0", cpu_instruction, I7);
    chk("wstart_rdy0", 32'(cpu_instruction_RDY_BSY), 32'h1);
    cycle();
    chk("wstart_instr1", cpu_instruction, I7);
    cycle();
    chk("wstart_done", 32'(done), 32'h1);
    chk("wstart_done_rdy", 32'(cpu_instruction_RDY_BSY), 32'h0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
